// File: rtl/wb_arb_pkg.sv
// Shared definitions for the writeback port arbiter.
// Contents: default widths and depth, the pending-entry layout and the
// queue-occupancy state encoding exposed on the debug state output.
package wb_arb_pkg;

  localparam int         DEF_XLEN    = 32;
  localparam int         DEF_DEPTH   = 2;
  localparam logic [4:0] DEF_LINK_RD = 5'd31;

  // One register-file write: destination and value.
  typedef struct packed {
    logic [4:0]          rd;
    logic [DEF_XLEN-1:0] data;
  } wb_entry_t;

  // Occupancy of the pending-write queue.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PEND  = 2'd1,
    ST_FULL  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle between the writeback stage, the arbiter and the register file.
// Upstream side : WB_we/WB_rd/WB_data_mem, WB_link_we/WB_link_addr, stall.
// Register side : rf_we/rf_rd/rf_wdata (registered write port).
// Bypass side   : q_rs lookup address, q_hit/q_data answer.
// Status        : overflow (sticky), state (queue occupancy, debug).
//
// Handshake: WB_we and WB_link_we are requests; stall is the inverted
// ready. A request is accepted in a cycle exactly when stall==0 at the
// rising edge; while stall==1 upstream must hold its inputs and present
// no requests, and any request it does present is dropped and flagged
// on overflow.
interface wb_port_arbiter_if #(
  parameter int XLEN = 32
);
  import wb_arb_pkg::*;

  logic            WB_we;
  logic [4:0]      WB_rd;
  logic [XLEN-1:0] WB_data_mem;
  logic            WB_link_we;
  logic [XLEN-1:0] WB_link_addr;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic            stall;
  logic            overflow;
  logic [4:0]      q_rs;
  logic            q_hit;
  logic [XLEN-1:0] q_data;
  arb_state_t      state;

  modport master (
    output WB_we, WB_rd, WB_data_mem, WB_link_we, WB_link_addr, q_rs,
    input  rf_we, rf_rd, rf_wdata, stall, overflow, q_hit, q_data, state
  );

  modport slave (
    input  WB_we, WB_rd, WB_data_mem, WB_link_we, WB_link_addr, q_rs,
    output rf_we, rf_rd, rf_wdata, stall, overflow, q_hit, q_data, state
  );

endinterface

// File: rtl/wb_pend_fifo.sv
// Ordered queue of pending register-file writes.
// Entry 0 is the oldest. Per cycle it can pop the head and append up to
// two entries (push_n = 0..2, entry 0 first). The caller guarantees the
// result never exceeds DEPTH.
// Ports: clk, rst (async, active-high), pop, push_n, push_rd0/1,
// push_data0/1, count, count_next, head_rd, head_data,
// lk_rs -> lk_hit/lk_data (youngest matching entry wins).
module wb_pend_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pop,
  input  logic [1:0]      push_n,
  input  logic [4:0]      push_rd0,
  input  logic [XLEN-1:0] push_data0,
  input  logic [4:0]      push_rd1,
  input  logic [XLEN-1:0] push_data1,
  output logic [CW-1:0]   count,
  output logic [CW-1:0]   count_next,
  output logic [4:0]      head_rd,
  output logic [XLEN-1:0] head_data,
  input  logic [4:0]      lk_rs,
  output logic            lk_hit,
  output logic [XLEN-1:0] lk_data
);

  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [4:0]      rd_n   [DEPTH];
  logic [XLEN-1:0] data_n [DEPTH];
  int              base;

  assign count_next = count - CW'(pop) + CW'(push_n);
  assign head_rd    = rd_q[0];
  assign head_data  = data_q[0];

  // Shift down on pop, then append behind the surviving entries.
  always_comb begin
    rd_n   = rd_q;
    data_n = data_q;
    base   = int'(count) - int'(pop);
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        rd_n[i]   = rd_q[i+1];
        data_n[i] = data_q[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (push_n != 2'd0 && i == base) begin
        rd_n[i]   = push_rd0;
        data_n[i] = push_data0;
      end
      if (push_n == 2'd2 && i == base + 1) begin
        rd_n[i]   = push_rd1;
        data_n[i] = push_data1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_q   <= '{default: '0};
      data_q <= '{default: '0};
    end else begin
      count  <= count_next;
      rd_q   <= rd_n;
      data_q <= data_n;
    end
  end

  // Scan oldest to youngest so the youngest valid match overrides.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count) && rd_q[i] == lk_rs) begin
        lk_hit  = 1'b1;
        lk_data = data_q[i];
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Serialises up to two writeback writes per cycle (data write and JALX
// link write) onto a single register-file write port.
// Candidates in program order: queue head, incoming data write, incoming
// link write. The oldest valid one goes to the rf_* registers, the rest
// are queued. Writes to register 0 are dropped.
// Ports: clk, rst (async, active-high), bus (slave side of
// wb_port_arbiter_if: WB_* requests, rf_* write port, stall, overflow,
// q_rs/q_hit/q_data bypass lookup, state debug).
// DEPTH must be at least 2.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int         XLEN    = DEF_XLEN,
  parameter logic [4:0] LINK_RD = DEF_LINK_RD,
  parameter int         DEPTH   = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  wb_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;
  logic            lk_hit;
  logic [XLEN-1:0] lk_data;

  logic            stall;
  logic            v_head, v_data, v_link;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [XLEN-1:0] iss_data;
  logic            pop;
  logic [1:0]      push_n;
  logic [4:0]      e0_rd, e1_rd;
  logic [XLEN-1:0] e0_data, e1_data;

  arb_state_t      state;
  logic            rf_we_q;
  logic [4:0]      rf_rd_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic            overflow_q;

  // Stall once only one slot (or none) is left, so that a worst-case
  // cycle of two new requests can always be absorbed.
  assign stall  = !rst && (count >= CW'(DEPTH - 1));

  assign v_head = (count != '0);
  assign v_data = !stall && bus.WB_we && (bus.WB_rd != 5'd0);
  assign v_link = !stall && bus.WB_link_we && (LINK_RD != 5'd0);

  // Issue the oldest valid candidate, enqueue the others in order.
  always_comb begin
    iss_valid = 1'b0;
    iss_rd    = '0;
    iss_data  = '0;
    pop       = 1'b0;
    push_n    = 2'd0;
    e0_rd     = '0;
    e0_data   = '0;
    e1_rd     = '0;
    e1_data   = '0;
    if (v_head) begin
      iss_valid = 1'b1;
      iss_rd    = head_rd;
      iss_data  = head_data;
      pop       = 1'b1;
      if (v_data) begin
        e0_rd   = bus.WB_rd;
        e0_data = bus.WB_data_mem;
        if (v_link) begin
          e1_rd   = LINK_RD;
          e1_data = bus.WB_link_addr;
          push_n  = 2'd2;
        end else begin
          push_n  = 2'd1;
        end
      end else if (v_link) begin
        e0_rd   = LINK_RD;
        e0_data = bus.WB_link_addr;
        push_n  = 2'd1;
      end
    end else if (v_data) begin
      iss_valid = 1'b1;
      iss_rd    = bus.WB_rd;
      iss_data  = bus.WB_data_mem;
      if (v_link) begin
        e0_rd   = LINK_RD;
        e0_data = bus.WB_link_addr;
        push_n  = 2'd1;
      end
    end else if (v_link) begin
      iss_valid = 1'b1;
      iss_rd    = LINK_RD;
      iss_data  = bus.WB_link_addr;
    end
  end

  wb_pend_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .pop        (pop),
    .push_n     (push_n),
    .push_rd0   (e0_rd),
    .push_data0 (e0_data),
    .push_rd1   (e1_rd),
    .push_data1 (e1_data),
    .count      (count),
    .count_next (count_next),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .lk_rs      (bus.q_rs),
    .lk_hit     (lk_hit),
    .lk_data    (lk_data)
  );

  // Occupancy FSM with the registered write port and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_EMPTY;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      rf_we_q <= iss_valid;
      if (iss_valid) begin
        rf_rd_q    <= iss_rd;
        rf_wdata_q <= iss_data;
      end
      if (stall && (bus.WB_we || bus.WB_link_we)) begin
        overflow_q <= 1'b1;
      end
      case (state)
        ST_EMPTY: if (count_next != '0) state <= ST_PEND;
        ST_PEND: begin
          if (count_next == '0)              state <= ST_EMPTY;
          else if (count_next == CW'(DEPTH)) state <= ST_FULL;
        end
        ST_FULL:  if (count_next < CW'(DEPTH)) state <= ST_PEND;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  // Bypass: queue (youngest first) beats the outgoing rf register.
  always_comb begin
    bus.q_hit  = 1'b0;
    bus.q_data = '0;
    if (bus.q_rs != 5'd0) begin
      if (lk_hit) begin
        bus.q_hit  = 1'b1;
        bus.q_data = lk_data;
      end else if (rf_we_q && rf_rd_q == bus.q_rs) begin
        bus.q_hit  = 1'b1;
        bus.q_data = rf_wdata_q;
      end
    end
  end

  assign bus.stall    = stall;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_rd    = rf_rd_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.overflow = overflow_q;
  assign bus.state    = state;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the arbiter.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int         XLEN    = 32;
  localparam int         DEPTH   = 2;
  localparam logic [4:0] LINK    = 5'd31;
  localparam int         ENTRY_W = $bits(wb_entry_t);

  logic clk;
  logic rst;

  wb_port_arbiter_if #(.XLEN(XLEN)) bus ();

  wb_port_arbiter #(
    .XLEN    (XLEN),
    .LINK_RD (LINK),
    .DEPTH   (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [ENTRY_W-1:0] exp_q[$];   // pending writes, oldest first
  logic               exp_we;
  logic [4:0]         exp_rd;
  logic [XLEN-1:0]    exp_data;
  logic               exp_ovf;

  function automatic logic model_stall();
    return exp_q.size() >= DEPTH - 1;
  endfunction

  function automatic arb_state_t model_state();
    if (exp_q.size() == 0)      return ST_EMPTY;
    if (exp_q.size() >= DEPTH)  return ST_FULL;
    return ST_PEND;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_we   = 1'b0;
    exp_rd   = '0;
    exp_data = '0;
    exp_ovf  = 1'b0;
  endtask

  task automatic model_lookup(input logic [4:0] rs, output logic hit,
                              output logic [XLEN-1:0] d);
    wb_entry_t e;
    hit = 1'b0;
    d   = '0;
    if (rs != 5'd0) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        e = wb_entry_t'(exp_q[i]);
        if (!hit && e.rd == rs) begin
          hit = 1'b1;
          d   = e.data;
        end
      end
      if (!hit && exp_we && exp_rd == rs) begin
        hit = 1'b1;
        d   = exp_data;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_idle();
    bus.WB_we        = 1'b0;
    bus.WB_rd        = '0;
    bus.WB_data_mem  = '0;
    bus.WB_link_we   = 1'b0;
    bus.WB_link_addr = '0;
  endtask

  // Present one cycle of inputs, clock it, update the model; returns
  // at posedge+1 with inputs back to idle.
  task automatic tick(input logic we, input logic [4:0] rd,
                      input logic [XLEN-1:0] d, input logic lwe,
                      input logic [XLEN-1:0] la);
    logic               stalled;
    logic [ENTRY_W-1:0] cand[$];
    wb_entry_t          e;
    bus.WB_we        = we;
    bus.WB_rd        = rd;
    bus.WB_data_mem  = d;
    bus.WB_link_we   = lwe;
    bus.WB_link_addr = la;
    @(posedge clk);
    stalled = model_stall();
    if (stalled && (we || lwe)) exp_ovf = 1'b1;
    cand = exp_q;
    if (!stalled) begin
      if (we && rd != 5'd0) cand.push_back({rd, d});
      if (lwe)              cand.push_back({LINK, la});
    end
    if (cand.size() > 0) begin
      e        = wb_entry_t'(cand.pop_front());
      exp_we   = 1'b1;
      exp_rd   = e.rd;
      exp_data = e.data;
    end else begin
      exp_we = 1'b0;
    end
    exp_q = cand;
    #1;
    drive_idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    bus.q_rs = '0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++; if (bus.rf_we !== 1'b0) $display("FAIL reset_rf_we: got %b want 0", bus.rf_we); else n_pass++;
    n_checks++; if (bus.rf_rd !== 5'd0) $display("FAIL reset_rf_rd: got %0d want 0", bus.rf_rd); else n_pass++;
    n_checks++; if (bus.rf_wdata !== '0) $display("FAIL reset_rf_wdata: got %h want 0", bus.rf_wdata); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", bus.overflow); else n_pass++;
    n_checks++; if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.stall); else n_pass++;
    n_checks++; if (bus.state !== ST_EMPTY) $display("FAIL reset_state: got %0d want %0d", bus.state, ST_EMPTY); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++; if (bus.stall !== 1'b0) $display("FAIL reset_release_stall: got %b want 0", bus.stall); else n_pass++;
  endtask

  task automatic test_single();
    n_checks++; if (bus.stall !== model_stall()) $display("FAIL single_pre_stall: got %b want %b", bus.stall, model_stall()); else n_pass++;
    tick(1'b1, 5'd5, 32'hA5, 1'b0, '0);
    n_checks++; if (bus.rf_we !== exp_we) $display("FAIL single_we: got %b want %b", bus.rf_we, exp_we); else n_pass++;
    n_checks++; if (bus.rf_rd !== exp_rd) $display("FAIL single_rd: got %0d want %0d", bus.rf_rd, exp_rd); else n_pass++;
    n_checks++; if (bus.rf_wdata !== exp_data) $display("FAIL single_data: got %h want %h", bus.rf_wdata, exp_data); else n_pass++;
    n_checks++; if (bus.stall !== model_stall()) $display("FAIL single_stall: got %b want %b", bus.stall, model_stall()); else n_pass++;
    tick(1'b0, '0, '0, 1'b0, '0);
    n_checks++; if (bus.rf_we !== exp_we) $display("FAIL single_idle_we: got %b want %b", bus.rf_we, exp_we); else n_pass++;
    n_checks++; if (bus.rf_rd !== exp_rd) $display("FAIL single_idle_rd_hold: got %0d want %0d", bus.rf_rd, exp_rd); else n_pass++;
    n_checks++; if (bus.rf_wdata !== exp_data) $display("FAIL single_idle_data_hold: got %h want %h", bus.rf_wdata, exp_data); else n_pass++;
  endtask

  task automatic test_pair();
    logic            h;
    logic [XLEN-1:0] d;
    tick(1'b1, 5'd3, 32'h11, 1'b1, 32'h400);
    n_checks++; if (bus.rf_we !== exp_we || bus.rf_rd !== exp_rd || bus.rf_wdata !== exp_data)
      $display("FAIL pair_first: got %b/%0d/%h want %b/%0d/%h", bus.rf_we, bus.rf_rd, bus.rf_wdata, exp_we, exp_rd, exp_data); else n_pass++;
    n_checks++; if (bus.stall !== model_stall()) $display("FAIL pair_stall: got %b want %b", bus.stall, model_stall()); else n_pass++;
    n_checks++; if (bus.state !== model_state()) $display("FAIL pair_state: got %0d want %0d", bus.state, model_state()); else n_pass++;
    foreach (exp_rd[i]) begin end
    bus.q_rs = 5'd31;
    #1;
    model_lookup(bus.q_rs, h, d);
    n_checks++; if (bus.q_hit !== h || bus.q_data !== d) $display("FAIL pair_q31: got %b/%h want %b/%h", bus.q_hit, bus.q_data, h, d); else n_pass++;
    bus.q_rs = 5'd0;
    #1;
    n_checks++; if (bus.q_hit !== 1'b0 || bus.q_data !== '0) $display("FAIL pair_q0: got %b/%h want 0/0", bus.q_hit, bus.q_data); else n_pass++;
    bus.q_rs = 5'd3;
    #1;
    model_lookup(bus.q_rs, h, d);
    n_checks++; if (bus.q_hit !== h || bus.q_data !== d) $display("FAIL pair_q3_rfreg: got %b/%h want %b/%h", bus.q_hit, bus.q_data, h, d); else n_pass++;
    tick(1'b0, '0, '0, 1'b0, '0);
    n_checks++; if (bus.rf_we !== exp_we || bus.rf_rd !== exp_rd || bus.rf_wdata !== exp_data)
      $display("FAIL pair_second: got %b/%0d/%h want %b/%0d/%h", bus.rf_we, bus.rf_rd, bus.rf_wdata, exp_we, exp_rd, exp_data); else n_pass++;
    n_checks++; if (bus.stall !== model_stall()) $display("FAIL pair_unstall: got %b want %b", bus.stall, model_stall()); else n_pass++;
    n_checks++; if (bus.state !== model_state()) $display("FAIL pair_state_empty: got %0d want %0d", bus.state, model_state()); else n_pass++;
  endtask

  task automatic test_same_reg();
    logic            h;
    logic [XLEN-1:0] d;
    tick(1'b1, 5'd31, 32'h55, 1'b1, 32'h66);
    n_checks++; if (bus.rf_rd !== exp_rd || bus.rf_wdata !== exp_data) $display("FAIL same_first: got %0d/%h want %0d/%h", bus.rf_rd, bus.rf_wdata, exp_rd, exp_data); else n_pass++;
    bus.q_rs = 5'd31;
    #1;
    model_lookup(bus.q_rs, h, d);
    n_checks++; if (bus.q_hit !== h || bus.q_data !== d) $display("FAIL same_q_newest: got %b/%h want %b/%h", bus.q_hit, bus.q_data, h, d); else n_pass++;
    tick(1'b0, '0, '0, 1'b0, '0);
    n_checks++; if (bus.rf_we !== exp_we || bus.rf_rd !== exp_rd || bus.rf_wdata !== exp_data)
      $display("FAIL same_second: got %b/%0d/%h want %b/%0d/%h", bus.rf_we, bus.rf_rd, bus.rf_wdata, exp_we, exp_rd, exp_data); else n_pass++;
  endtask

  task automatic test_rd_zero();
    n_checks++; if (bus.stall !== model_stall()) $display("FAIL rd0_pre_stall: got %b want %b", bus.stall, model_stall()); else n_pass++;
    tick(1'b1, 5'd0, 32'h12, 1'b1, 32'h80);
    n_checks++; if (bus.rf_we !== exp_we || bus.rf_rd !== exp_rd || bus.rf_wdata !== exp_data)
      $display("FAIL rd0_link: got %b/%0d/%h want %b/%0d/%h", bus.rf_we, bus.rf_rd, bus.rf_wdata, exp_we, exp_rd, exp_data); else n_pass++;
    n_checks++; if (bus.stall !== model_stall()) $display("FAIL rd0_stall: got %b want %b", bus.stall, model_stall()); else n_pass++;
    tick(1'b0, '0, '0, 1'b0, '0);
    n_checks++; if (bus.rf_we !== exp_we) $display("FAIL rd0_after_we: got %b want %b", bus.rf_we, exp_we); else n_pass++;
  endtask

  task automatic test_overflow();
    tick(1'b1, 5'd7, 32'h70, 1'b1, 32'h700);
    n_checks++; if (bus.overflow !== exp_ovf) $display("FAIL ovf_before: got %b want %b", bus.overflow, exp_ovf); else n_pass++;
    tick(1'b1, 5'd9, 32'h99, 1'b0, '0);
    n_checks++; if (bus.overflow !== exp_ovf) $display("FAIL ovf_set: got %b want %b", bus.overflow, exp_ovf); else n_pass++;
    n_checks++; if (bus.rf_we !== exp_we || bus.rf_rd !== exp_rd || bus.rf_wdata !== exp_data)
      $display("FAIL ovf_queue_issue: got %b/%0d/%h want %b/%0d/%h", bus.rf_we, bus.rf_rd, bus.rf_wdata, exp_we, exp_rd, exp_data); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, '0, '0, 1'b0, '0);
      n_checks++; if (bus.overflow !== exp_ovf || bus.rf_we !== exp_we)
        $display("FAIL ovf_idle_%0d: got ovf=%b we=%b want ovf=%b we=%b", i, bus.overflow, bus.rf_we, exp_ovf, exp_we); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 5'd4, 32'h44, 1'b1, 32'h800);
    bus.q_rs = 5'd31;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.rf_we !== 1'b0 || bus.rf_rd !== 5'd0 || bus.rf_wdata !== '0)
      $display("FAIL rstmid_rf: got %b/%0d/%h want 0/0/0", bus.rf_we, bus.rf_rd, bus.rf_wdata); else n_pass++;
    n_checks++; if (bus.stall !== 1'b0 || bus.overflow !== 1'b0) $display("FAIL rstmid_flags: got stall=%b ovf=%b want 0/0", bus.stall, bus.overflow); else n_pass++;
    n_checks++; if (bus.q_hit !== 1'b0) $display("FAIL rstmid_qhit: got %b want 0", bus.q_hit); else n_pass++;
    n_checks++; if (bus.state !== ST_EMPTY) $display("FAIL rstmid_state: got %0d want %0d", bus.state, ST_EMPTY); else n_pass++;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (bus.stall !== 1'b0) $display("FAIL rstmid_release_stall: got %b want 0", bus.stall); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0, '0, 1'b0, '0);
      n_checks++; if (bus.rf_we !== exp_we) $display("FAIL rstmid_no_issue_%0d: got %b want %b", i, bus.rf_we, exp_we); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic            we, lwe, h;
    logic [4:0]      rd;
    logic [XLEN-1:0] d, la, qd;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
      end
      bus.q_rs = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) bus.q_rs = exp_rd;
      #1;
      model_lookup(bus.q_rs, h, qd);
      n_checks++; if (bus.q_hit !== h || bus.q_data !== qd) $display("FAIL rand_q_%0d: rs=%0d got %b/%h want %b/%h", n, bus.q_rs, bus.q_hit, bus.q_data, h, qd); else n_pass++;
      n_checks++; if (bus.stall !== model_stall()) $display("FAIL rand_stall_%0d: got %b want %b", n, bus.stall, model_stall()); else n_pass++;
      if (model_stall()) begin
        we  = ($urandom_range(0, 7) == 0);
        lwe = 1'b0;
      end else begin
        we  = 1'($urandom_range(0, 1));
        lwe = 1'($urandom_range(0, 1));
      end
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      d  = $urandom;
      la = $urandom;
      tick(we, rd, d, lwe, la);
      n_checks++; if (bus.rf_we !== exp_we || bus.rf_rd !== exp_rd || bus.rf_wdata !== exp_data)
        $display("FAIL rand_rf_%0d: got %b/%0d/%h want %b/%0d/%h", n, bus.rf_we, bus.rf_rd, bus.rf_wdata, exp_we, exp_rd, exp_data); else n_pass++;
      n_checks++; if (bus.overflow !== exp_ovf || bus.state !== model_state())
        $display("FAIL rand_status_%0d: got ovf=%b st=%0d want ovf=%b st=%0d", n, bus.overflow, bus.state, exp_ovf, model_state()); else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    drive_idle();
    bus.q_rs = '0;
    model_reset();
    test_reset();
    test_single();
    test_pair();
    test_same_reg();
    test_rd_zero();
    test_overflow();
    test_reset();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- XLEN, 32, datapath width.
- LINK_RD, 5'd31, destination register for link writes.
- DEPTH, 2, pending-write queue depth.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, asynchronous, active-high reset.
- WB_we, in, 1, writeback data write request.
- WB_rd, in, 5, writeback data destination.
- WB_data_mem, in, XLEN, writeback data.
- WB_link_we, in, 1, link write request (JALX).
- WB_link_addr, in, XLEN, link value.
- rf_we, out, 1, register-file write enable (registered).
- rf_rd, out, 5, register-file write address (registered).
- rf_wdata, out, XLEN, register-file write data (registered).
- stall, out, 1, upstream must hold WB inputs and present no requests.
- overflow, out, 1, sticky error flag.
- q_rs, in, 5, bypass lookup address.
- q_hit, out, 1, q_rs matches a pending or outgoing write.
- q_data, out, XLEN, newest data for q_rs.

Function
REQ-003 The register file has one write port; the block SHALL serialise up to two writes per cycle onto it.
REQ-004 A request with destination 0 SHALL be discarded (WB_rd==0 with WB_we, or LINK_RD==0 with WB_link_we).
REQ-005 Program order, oldest first: queue head, then the incoming data write, then the incoming link write.
REQ-006 Each cycle, the oldest valid candidate SHALL be issued to the rf_* registers; all remaining valid candidates SHALL be enqueued in order.
REQ-007 Issue latency SHALL be exactly one cycle: a candidate issued in cycle N appears on rf_* in cycle N+1, with rf_we=1 for exactly one cycle.
REQ-008 rf_we SHALL be 0 in any cycle following a cycle with no valid candidate; rf_rd and rf_wdata then hold their previous values.
REQ-009 Queue count range is 0..DEPTH; net change per cycle is at most +1, as a simultaneous enqueue and dequeue keeps the count.
REQ-010 State machine:
- EMPTY (count==0) -> PEND when two valid requests arrive together.
- PEND -> EMPTY when the last entry issues with no new enqueue.
- PEND -> FULL when count reaches DEPTH.
- FULL -> PEND after one issue with no enqueue.
REQ-011 stall SHALL be combinational, asserted when count >= DEPTH-1, and deasserted in the same cycle count drops below DEPTH-1.
REQ-012 Inputs SHALL be ignored while stall=1.
REQ-013 If requests arrive while stall=1, overflow SHALL set and remain set until reset; the queue is unchanged.
REQ-014 q_hit/q_data SHALL be combinational over queue entries and the outgoing rf register. The newest match wins, in priority order: youngest queue entry, then older queue entry, then rf register. q_rs==0 SHALL give q_hit=0, q_data=0.
REQ-015 When q_hit=0, q_data SHALL be 0.
REQ-016 Two queued writes to the same register SHALL both issue in order; no merging.

Reset
REQ-017 rst SHALL act asynchronously: count=0, state EMPTY, rf_we=0, rf_rd=0, rf_wdata=0, overflow=0.
REQ-018 Reset mid-drain SHALL discard all queued entries; no further rf_we pulses for them after rst deasserts.
REQ-019 stall SHALL be 0 while rst=1 and in the first cycle after release.

Structure
REQ-020 Shared package wb_arb_pkg: entry typedef {rd[4:0], data[XLEN-1:0]}, DEPTH default, LINK_RD default, state encoding.
REQ-021 One sub-module, wb_pend_fifo: DEPTH-entry ordered queue with push, pop and age-ordered lookup; arbitration, stall and the rf register stay in the top level.

Verification
REQ-022 Scenario: single write WB_we=1, rd=5, data=0xA5 with count=0 -> next cycle rf_we=1, rf_rd=5, rf_wdata=0xA5; stall stays 0.
REQ-023 Scenario: WB_we=1, rd=3, data=0x11 together with link_we=1, link_addr=0x400 ->
- cycle+1: rd=3, data=0x11.
- cycle+2: rd=31, data=0x400.
- stall=1 for the one cycle count==1.
REQ-024 Scenario: during a stall, drive q_rs=31 -> q_hit=1, q_data=0x400. q_rs=0 -> q_hit=0.
REQ-025 Scenario: request asserted while stall=1 -> overflow=1; it persists through 10 idle cycles, and queue contents issue unchanged.
REQ-026 Scenario: WB_rd=0 with link_we=1, link_addr=0x80 -> only the rd=31 write issues, one cycle later; no stall.
REQ-027 Scenario: rst pulsed mid-cycle with count=1 -> all outputs 0 immediately, no pending write issued after release.
